// File: rtl/screen_draw_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// screen_draw_scheduler_pkg
// Shared definitions for the screen draw scheduler: pixel-port field widths,
// the BLACK colour constant, scheduler state encoding, VGA source selector
// encoding and the packed pixel-port bundle used between top and mux.
// -----------------------------------------------------------------------------
package screen_draw_scheduler_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 9;

    localparam logic [COLOR_W-1:0] BLACK = '0;

    typedef enum logic [2:0] {
        IDLE,
        ERASE_KICK,
        ERASE_WAIT,
        DRAW_A,
        DRAW_B
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ERASE,
        SRC_C0,
        SRC_C1
    } src_t;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
        logic               write;
    } pixel_t;

endpackage

// File: rtl/screen_draw_scheduler_pixel_port_mux.sv
// -----------------------------------------------------------------------------
// pixel_port_mux
// Registered 3-source to 1 pixel-port select. The selected source's pixel
// appears on o_pix one cycle later; with no owner the output carries an idle
// pixel (write low, coordinates zero, colour BLACK).
//
// Ports
//   i_clock   : system clock
//   i_resetn  : synchronous active-low reset
//   i_sel     : which source owns the port this cycle
//   i_erase   : eraser pixel port
//   i_c0      : client 0 pixel port
//   i_c1      : client 1 pixel port
//   o_pix     : registered pixel port toward the VGA adapter
// -----------------------------------------------------------------------------
module pixel_port_mux
    import screen_draw_scheduler_pkg::*;
(
    input  logic   i_clock,
    input  logic   i_resetn,
    input  src_t   i_sel,
    input  pixel_t i_erase,
    input  pixel_t i_c0,
    input  pixel_t i_c1,
    output pixel_t o_pix
);

    pixel_t r_pix;

    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_pix <= '{x: '0, y: '0, color: BLACK, write: 1'b0};
        end else begin
            case (i_sel)
                SRC_ERASE: r_pix <= i_erase;
                SRC_C0:    r_pix <= i_c0;
                SRC_C1:    r_pix <= i_c1;
                default:   r_pix <= '{x: '0, y: '0, color: BLACK, write: 1'b0};
            endcase
        end
    end

    assign o_pix = r_pix;

endmodule

// File: rtl/screen_draw_scheduler.sv
// -----------------------------------------------------------------------------
// screen_draw_scheduler
// Per-frame sequencer for a shared VGA pixel port: on frame_tick it kicks the
// lane eraser and lets it own the port until done, then serves two draw
// clients in round-robin order (DRAW_A serves rr_ptr, DRAW_B the other).
//
// Optional feature: define SCHED_WATCHDOG_EN to add a per-state cycle counter
// that forces the state forward after WD_LIMIT cycles and sets wd_fault.
//
// Ports
//   Clock, Resetn                      : clock, synchronous active-low reset
//   frame_tick                         : start-of-frame pulse
//   erase_enable / erase_active        : eraser start level / eraser busy
//   erase_x/y/color/write              : eraser pixel port
//   cN_req, cN_done, cN_gnt (N=0,1)    : client handshake
//   cN_x/y/color/write                 : client pixel ports
//   vga_x/y/color/write                : registered pixel port to VGA adapter
//   busy, frame_overrun, wd_fault      : status (last two sticky)
// -----------------------------------------------------------------------------
module screen_draw_scheduler
    import screen_draw_scheduler_pkg::*;
#(
    parameter int unsigned WD_LIMIT = 400000
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               frame_tick,
    output logic               erase_enable,
    input  logic               erase_active,
    input  logic [X_W-1:0]     erase_x,
    input  logic [Y_W-1:0]     erase_y,
    input  logic [COLOR_W-1:0] erase_color,
    input  logic               erase_write,
    input  logic               c0_req,
    input  logic               c0_done,
    input  logic [X_W-1:0]     c0_x,
    input  logic [Y_W-1:0]     c0_y,
    input  logic [COLOR_W-1:0] c0_color,
    input  logic               c0_write,
    output logic               c0_gnt,
    input  logic               c1_req,
    input  logic               c1_done,
    input  logic [X_W-1:0]     c1_x,
    input  logic [Y_W-1:0]     c1_y,
    input  logic [COLOR_W-1:0] c1_color,
    input  logic               c1_write,
    output logic               c1_gnt,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_color,
    output logic               vga_write,
    output logic               busy,
    output logic               frame_overrun,
    output logic               wd_fault
);

    state_t r_state;
    state_t w_nextState;
    logic   r_rrPtr;
    logic   r_first;
    logic   r_frameOverrun;
    logic   w_inDraw;
    logic   w_servedClient;
    logic   w_servedReq;
    logic   w_servedDone;
    logic   w_grant;
    logic   w_wdExpire;
    src_t   w_sel;
    pixel_t w_erasePix;
    pixel_t w_c0Pix;
    pixel_t w_c1Pix;
    pixel_t w_vgaPix;

    assign w_inDraw       = (r_state == DRAW_A) || (r_state == DRAW_B);
    assign w_servedClient = (r_state == DRAW_A) ? r_rrPtr : ~r_rrPtr;
    assign w_servedReq    = w_servedClient ? c1_req  : c0_req;
    assign w_servedDone   = w_servedClient ? c1_done : c0_done;

    // On the first cycle of a DRAW state the grant follows req, so an idle
    // client is skipped without ever seeing gnt. Once granted, gnt holds
    // through the cycle where done/req-fall is seen and drops on the next.
    assign w_grant = w_inDraw && (w_servedReq || !r_first);
    assign c0_gnt  = w_grant && !w_servedClient;
    assign c1_gnt  = w_grant &&  w_servedClient;

    assign erase_enable = (r_state == ERASE_KICK) || (r_state == ERASE_WAIT);
    assign busy         = (r_state != IDLE);
    assign frame_overrun = r_frameOverrun;

`ifdef SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] r_wdCount;
    logic            r_wdFault;

    // Counts cycles spent in the current state; expiry after WD_LIMIT cycles
    // in any non-idle state.
    assign w_wdExpire = (r_state != IDLE) && (r_wdCount == WD_W'(WD_LIMIT - 1));

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_wdCount <= '0;
            r_wdFault <= 1'b0;
        end else begin
            if ((w_nextState != r_state) || (r_state == IDLE)) begin
                r_wdCount <= '0;
            end else begin
                r_wdCount <= r_wdCount + 1'b1;
            end
            if (w_wdExpire) begin
                r_wdFault <= 1'b1;
            end
        end
    end

    assign wd_fault = r_wdFault;
`else
    assign w_wdExpire = 1'b0;
    assign wd_fault   = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state        <= IDLE;
            r_rrPtr        <= 1'b0;
            r_first        <= 1'b1;
            r_frameOverrun <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_first <= (w_nextState != r_state);
            if ((r_state == DRAW_B) && (w_nextState != DRAW_B)) begin
                r_rrPtr <= ~r_rrPtr;
            end
            if (frame_tick && (r_state != IDLE)) begin
                r_frameOverrun <= 1'b1;
            end
        end
    end

    // A watchdog expiry in either erase state jumps straight to DRAW_A so
    // that erase_enable is dropped rather than lingering in ERASE_WAIT.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (frame_tick) w_nextState = ERASE_KICK;
            end
            ERASE_KICK: begin
                if (w_wdExpire)        w_nextState = DRAW_A;
                else if (erase_active) w_nextState = ERASE_WAIT;
            end
            ERASE_WAIT: begin
                if (w_wdExpire || !erase_active) w_nextState = DRAW_A;
            end
            DRAW_A: begin
                if (w_wdExpire || !w_servedReq || w_servedDone) w_nextState = DRAW_B;
            end
            DRAW_B: begin
                if (w_wdExpire || !w_servedReq || w_servedDone) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_sel = SRC_NONE;
        if (erase_enable) w_sel = SRC_ERASE;
        else if (c0_gnt)  w_sel = SRC_C0;
        else if (c1_gnt)  w_sel = SRC_C1;
    end

    assign w_erasePix = '{x: erase_x, y: erase_y, color: erase_color, write: erase_write};
    assign w_c0Pix    = '{x: c0_x, y: c0_y, color: c0_color, write: c0_write};
    assign w_c1Pix    = '{x: c1_x, y: c1_y, color: c1_color, write: c1_write};

    pixel_port_mux u_pixelPortMux (
        .i_clock  (Clock),
        .i_resetn (Resetn),
        .i_sel    (w_sel),
        .i_erase  (w_erasePix),
        .i_c0     (w_c0Pix),
        .i_c1     (w_c1Pix),
        .o_pix    (w_vgaPix)
    );

    assign vga_x     = w_vgaPix.x;
    assign vga_y     = w_vgaPix.y;
    assign vga_color = w_vgaPix.color;
    assign vga_write = w_vgaPix.write;

endmodule
